// File: rtl/store_split_unit.sv
// rtl/store_split_unit.sv - store request to one or two lane-aligned bus beats with byte masks
module store_split_unit #(
    parameter int XLEN            = 32,
    parameter bit MISALIGNED_TRAP = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic              done,
    output logic              fault
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic [XLEN-1:0]   addr0_q;
    logic [2*XLEN-1:0] data_q;
    logic [2*NB-1:0]   mask_q;
    logic              split_q;
    logic              fault_q;

    logic [OW-1:0]     off;
    int                sz;
    logic [NB-1:0]     byte_en;
    logic [XLEN-1:0]   data_mask;
    logic [2*XLEN-1:0] wide_data;
    logic [2*NB-1:0]   wide_mask;
    logic              req_split;
    logic              req_illegal;
    logic              req_fault;

    // Steer the incoming request onto a two-word window; only used at acceptance.
    always_comb begin
        off = req_addr[OW-1:0];
        case (req_op)
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            2'b10:   sz = 4;
            default: sz = 8;
        endcase
        byte_en   = '0;
        data_mask = '0;
        for (int i = 0; i < NB; i++) begin
            byte_en[i]          = (i < sz);
            data_mask[8*i +: 8] = {8{byte_en[i]}};
        end
        wide_data   = {{XLEN{1'b0}}, req_data & data_mask} << {off, 3'b000};
        wide_mask   = {{NB{1'b0}}, byte_en} << off;
        req_split   = |wide_mask[2*NB-1:NB];
        req_illegal = (req_op == 2'b11) && (XLEN != 64);
        req_fault   = req_illegal || (req_split && MISALIGNED_TRAP);
    end

    // State register and request field capture; fields are frozen until the next IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr0_q <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                addr0_q <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
                data_q  <= wide_data;
                mask_q  <= wide_mask;
                split_q <= req_split;
                fault_q <= req_fault;
            end
        end
    end

    // Next-state decode; mem_ready only influences this path.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = req_fault ? RESP : BEAT0;
            BEAT0:   if (mem_ready) state_n = split_q ? BEAT1 : RESP;
            BEAT1:   if (mem_ready) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from registered state and latched fields only.
    always_comb begin
        req_ready = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        done      = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = addr0_q;
                mem_wdata = data_q[XLEN-1:0];
                mem_wmask = mask_q[NB-1:0];
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = addr0_q + XLEN'(NB);
                mem_wdata = data_q[2*XLEN-1:XLEN];
                mem_wmask = mask_q[2*NB-1:NB];
            end
            RESP: begin
                done  = 1'b1;
                fault = fault_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_split_unit.sv
// tb/tb_store_split_unit.sv - directed checks of store_split_unit, split and trap variants
module tb_store_split_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        mem_ready;

    logic        req_valid0, req_ready0, mem_valid0, done0, fault0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [3:0]  mem_wmask0;

    logic        req_valid1, req_ready1, mem_valid1, done1, fault1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [3:0]  mem_wmask1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    store_split_unit #(.XLEN(32), .MISALIGNED_TRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_op(req_op), .req_data(req_data),
        .mem_valid(mem_valid0), .mem_ready(mem_ready),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_wmask(mem_wmask0),
        .done(done0), .fault(fault0)
    );

    store_split_unit #(.XLEN(32), .MISALIGNED_TRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_op(req_op), .req_data(req_data),
        .mem_valid(mem_valid1), .mem_ready(mem_ready),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
        .done(done1), .fault(fault1)
    );

    task automatic test_reset();
        rst = 1'b1;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_addr = '0; req_op = '0; req_data = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({req_ready0, mem_valid0, done0, fault0} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 1000", {req_ready0, mem_valid0, done0, fault0});
        end
        tests++;
        if ({mem_addr0, mem_wdata0, mem_wmask0} !== 68'h0) begin
            fails++;
            $display("FAIL reset_beat got %h %h %b want zeros", mem_addr0, mem_wdata0, mem_wmask0);
        end
        tests++;
        if ({req_ready1, mem_valid1, done1, fault1} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl_trap got %b want 1000", {req_ready1, mem_valid1, done1, fault1});
        end
        @(posedge clk); #1;
    endtask

    // Entered and left at posedge+1 with both units idle.
    task automatic test_single(input string name, input logic [31:0] addr, input logic [1:0] op,
                               input logic [31:0] data, input logic [31:0] ea,
                               input logic [31:0] ed, input logic [3:0] em);
        mem_ready = 1'b1;
        req_addr = addr; req_op = op; req_data = data; req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_addr = addr ^ 32'h0000_0F0F; req_data = ~data; req_op = ~op;
        @(negedge clk);
        tests++;
        if ({req_ready0, mem_valid0, mem_addr0, mem_wdata0, mem_wmask0} !== {2'b01, ea, ed, em}) begin
            fails++;
            $display("FAIL %s beat got rdy=%b v=%b %h %h %b want rdy=0 v=1 %h %h %b", name,
                     req_ready0, mem_valid0, mem_addr0, mem_wdata0, mem_wmask0, ea, ed, em);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({mem_valid0, done0, fault0} !== 3'b010) begin
            fails++;
            $display("FAIL %s resp got v/done/fault=%b want 010", name, {mem_valid0, done0, fault0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_split(input string name, input logic [31:0] addr, input logic [1:0] op,
                              input logic [31:0] data,
                              input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] m0,
                              input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] m1);
        mem_ready = 1'b1;
        req_addr = addr; req_op = op; req_data = data; req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_data = ~data;
        @(negedge clk);
        tests++;
        if ({mem_valid0, mem_addr0, mem_wdata0, mem_wmask0} !== {1'b1, a0, d0, m0}) begin
            fails++;
            $display("FAIL %s beat0 got v=%b %h %h %b want v=1 %h %h %b", name,
                     mem_valid0, mem_addr0, mem_wdata0, mem_wmask0, a0, d0, m0);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({mem_valid0, done0, mem_addr0, mem_wdata0, mem_wmask0} !== {2'b10, a1, d1, m1}) begin
            fails++;
            $display("FAIL %s beat1 got v=%b done=%b %h %h %b want v=1 done=0 %h %h %b", name,
                     mem_valid0, done0, mem_addr0, mem_wdata0, mem_wmask0, a1, d1, m1);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({mem_valid0, done0, fault0} !== 3'b010) begin
            fails++;
            $display("FAIL %s resp got v/done/fault=%b want 010", name, {mem_valid0, done0, fault0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_trap(input string name, input logic [31:0] addr, input logic [1:0] op);
        mem_ready = 1'b1;
        req_addr = addr; req_op = op; req_data = 32'h5566_7788; req_valid1 = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_valid1 !== 1'b0 || done1 !== 1'b0) begin
            fails++;
            $display("FAIL %s idle got v=%b done=%b want 0 0", name, mem_valid1, done1);
        end
        @(posedge clk); #1 req_valid1 = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_valid1, done1, fault1} !== 3'b011) begin
            fails++;
            $display("FAIL %s resp got v/done/fault=%b want 011", name, {mem_valid1, done1, fault1});
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({req_ready1, mem_valid1, done1, fault1} !== 4'b1000) begin
            fails++;
            $display("FAIL %s after got rdy/v/done/fault=%b want 1000", name,
                     {req_ready1, mem_valid1, done1, fault1});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_op();
        mem_ready = 1'b1;
        req_addr = 32'h0000_3000; req_op = 2'b11; req_data = 32'h1; req_valid0 = 1'b1;
        @(posedge clk); #1 req_valid0 = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_valid0, done0, fault0} !== 3'b011) begin
            fails++;
            $display("FAIL illegal_sd got v/done/fault=%b want 011", {mem_valid0, done0, fault0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_beat1();
        mem_ready = 1'b1;
        req_addr = 32'h0000_1003; req_op = 2'b01; req_data = 32'h0000_BEEF; req_valid0 = 1'b1;
        @(posedge clk); #1 req_valid0 = 1'b0;
        @(posedge clk); #1 mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({mem_valid0, done0, mem_addr0, mem_wdata0, mem_wmask0} !==
                {2'b10, 32'h0000_1004, 32'h0000_00BE, 4'b0001}) begin
                fails++;
                $display("FAIL wait_hold%0d got v=%b done=%b %h %h %b want v=1 done=0 00001004 000000be 0001",
                         i, mem_valid0, done0, mem_addr0, mem_wdata0, mem_wmask0);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if ({mem_valid0, done0} !== 2'b10) begin
            fails++;
            $display("FAIL wait_last got v/done=%b want 10", {mem_valid0, done0});
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({mem_valid0, done0, fault0} !== 3'b010) begin
            fails++;
            $display("FAIL wait_done got v/done/fault=%b want 010", {mem_valid0, done0, fault0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_beat();
        mem_ready = 1'b1;
        req_addr = 32'h0000_1003; req_op = 2'b01; req_data = 32'h0000_BEEF; req_valid0 = 1'b1;
        @(posedge clk); #1 req_valid0 = 1'b0;
        @(posedge clk); #1 mem_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_valid0, req_ready0, done0} !== 3'b010) begin
            fails++;
            $display("FAIL rst_mid got v/rdy/done=%b want 010", {mem_valid0, req_ready0, done0});
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({mem_valid0, done0} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_nodone got v/done=%b want 00", {mem_valid0, done0});
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single("sw_aligned", 32'h0000_1000, 2'b10, 32'h1122_3344, 32'h0000_1000, 32'h1122_3344, 4'b1111);
        test_single("sb_lane3",   32'h0000_2003, 2'b00, 32'h1234_56AB, 32'h0000_2000, 32'hAB00_0000, 4'b1000);
        test_single("sh_lane2",   32'h0000_1002, 2'b01, 32'h9999_BEEF, 32'h0000_1000, 32'hBEEF_0000, 4'b1100);
        test_split("sh_split", 32'h0000_1003, 2'b01, 32'h0000_BEEF,
                   32'h0000_1000, 32'hEF00_0000, 4'b1000, 32'h0000_1004, 32'h0000_00BE, 4'b0001);
        test_split("sw_wrap", 32'hFFFF_FFFE, 2'b10, 32'hCAFE_BABE,
                   32'hFFFF_FFFC, 32'hBABE_0000, 4'b1100, 32'h0000_0000, 32'h0000_CAFE, 4'b0011);
        test_split("sw_off1", 32'h0000_1001, 2'b10, 32'hAABB_CCDD,
                   32'h0000_1000, 32'hBBCC_DD00, 4'b1110, 32'h0000_1004, 32'h0000_00AA, 4'b0001);
        test_trap("trap_sw_mis", 32'h0000_1001, 2'b10);
        test_trap("trap_sd",     32'h0000_1000, 2'b11);
        test_illegal_op();
        test_wait_beat1();
        test_reset_mid_beat();
        test_single("sw_after_rst", 32'h0000_4004, 2'b10, 32'hDEAD_BEEF, 32'h0000_4004, 32'hDEAD_BEEF, 4'b1111);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
